// File: rtl/vga_console_if.sv
// Byte-stream input and VRAM write-port bundle for the text console.
// Handshake: a byte transfers on a rising clk edge where in_valid and in_ready are both 1; the producer holds in_data stable while in_valid waits.
interface vga_console_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] vram_waddr;
  logic [7:0]  vram_wdata;
  logic        vram_we;
  logic [5:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic [1:0]  dbg_state;

  modport master (
    output in_data, in_valid,
    input  in_ready, vram_waddr, vram_wdata, vram_we, cursor_col, cursor_row, dbg_state
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, vram_waddr, vram_wdata, vram_we, cursor_col, cursor_row, dbg_state
  );
endinterface

// File: rtl/vga_console.sv
// Teletype-style text console: turns a byte stream into VRAM cell writes,
// handling cursor motion, line wrap, backspace and screen/line clears.
module vga_console #(
  parameter int         COLS  = 40,
  parameter int         ROWS  = 30,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic          clk,
  input  logic          rst_n,
  vga_console_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CLR_LINE = 2'd1,
    S_CLR_ALL  = 2'd2
  } state_t;

  localparam logic [10:0] COLS_A    = 11'(COLS);
  localparam logic [10:0] LAST_CELL = 11'(ROWS * COLS - 1);
  localparam logic [5:0]  LAST_COL  = 6'(COLS - 1);
  localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);

  state_t      state_q, state_d;
  logic [5:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic [10:0] row_base_q, row_base_d;
  logic [10:0] clr_addr_q, clr_addr_d;
  logic [10:0] clr_last_q, clr_last_d;
  logic        we_q, we_d;
  logic [10:0] waddr_q, waddr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        ready_q, ready_d;

  logic        accept;
  logic [4:0]  nl_row;
  logic [10:0] nl_base;
  logic [10:0] cur_addr;
  logic        printable;

  assign accept    = ready_q && bus.in_valid;
  assign cur_addr  = row_base_q + 11'(col_q);
  assign printable = (bus.in_data >= 8'h20) && (bus.in_data != 8'h7F);

  // Row base moves in COLS steps so no multiplier is needed for cell addresses.
  always_comb begin
    nl_row  = (row_q == LAST_ROW) ? 5'd0  : row_q + 5'd1;
    nl_base = (row_q == LAST_ROW) ? 11'd0 : row_base_q + COLS_A;
  end

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    clr_addr_d = clr_addr_q;
    clr_last_d = clr_last_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    ready_d    = ready_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bus.in_data == 8'h0A || (printable && col_q == LAST_COL)) begin
            col_d      = 6'd0;
            row_d      = nl_row;
            row_base_d = nl_base;
            clr_addr_d = nl_base;
            clr_last_d = nl_base + COLS_A - 11'd1;
            state_d    = S_CLR_LINE;
            ready_d    = 1'b0;
          end
          if (printable) begin
            we_d    = 1'b1;
            waddr_d = cur_addr;
            wdata_d = bus.in_data;
            if (col_q != LAST_COL) col_d = col_q + 6'd1;
          end else if (bus.in_data == 8'h0D) begin
            col_d = 6'd0;
          end else if (bus.in_data == 8'h08) begin
            if (col_q != 6'd0) begin
              col_d   = col_q - 6'd1;
              we_d    = 1'b1;
              waddr_d = cur_addr - 11'd1;
              wdata_d = BLANK;
            end
          end else if (bus.in_data == 8'h0C) begin
            col_d      = 6'd0;
            row_d      = 5'd0;
            row_base_d = 11'd0;
            clr_addr_d = 11'd0;
            clr_last_d = LAST_CELL;
            state_d    = S_CLR_ALL;
            ready_d    = 1'b0;
          end
        end
      end
      S_CLR_LINE, S_CLR_ALL: begin
        we_d    = 1'b1;
        waddr_d = clr_addr_q;
        wdata_d = BLANK;
        if (clr_addr_q == clr_last_q) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
        end else begin
          clr_addr_d = clr_addr_q + 11'd1;
        end
      end
      default: begin
        state_d = S_CLR_ALL;
        ready_d = 1'b0;
      end
    endcase
  end

  // Reset lands in CLR_ALL so the screen is wiped before the first byte is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_CLR_ALL;
      col_q      <= 6'd0;
      row_q      <= 5'd0;
      row_base_q <= 11'd0;
      clr_addr_q <= 11'd0;
      clr_last_q <= LAST_CELL;
      we_q       <= 1'b0;
      waddr_q    <= 11'd0;
      wdata_q    <= 8'd0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
      clr_addr_q <= clr_addr_d;
      clr_last_q <= clr_last_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      ready_q    <= ready_d;
    end
  end

  assign bus.in_ready   = ready_q;
  assign bus.vram_we    = we_q;
  assign bus.vram_waddr = waddr_q;
  assign bus.vram_wdata = wdata_q;
  assign bus.cursor_col = col_q;
  assign bus.cursor_row = row_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: doc/vga_console.md
VGA_CONSOLE -- requirements
Module: vga_console

Interface
REQ-001 Parameter COLS, default 40, characters per row.
REQ-002 Parameter ROWS, default 30, rows per screen.
REQ-003 Parameter BLANK, default 8'h20, byte written when clearing a cell.
REQ-004 clk  input  1  sole clock; also the VRAM write clock.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_data  input  8  character or control byte.
REQ-007 in_valid  input  1  in_data is valid.
REQ-008 in_ready  output  1  block accepts in_data this cycle.
REQ-009 vram_waddr  output  11  VRAM write address; cell address = row*COLS + col.
REQ-010 vram_wdata  output  8  VRAM write data.
REQ-011 vram_we  output  1  VRAM write strobe, one cell per cycle.
REQ-012 cursor_col  output  6  current column, 0..COLS-1.
REQ-013 cursor_row  output  5  current row, 0..ROWS-1.

Function
REQ-014 The block SHALL accept a byte only on a cycle where in_valid and in_ready are both 1; in_ready SHALL be 1 only in state IDLE.
REQ-015 States SHALL be IDLE, CLR_LINE and CLR_ALL; all outputs SHALL be registered.
REQ-016 A printable byte (0x20..0xFF except 0x7F) accepted on cycle N SHALL produce vram_we=1 on cycle N+1, with vram_waddr set to the cursor cell and vram_wdata set to the byte; the cursor SHALL then advance one column.
REQ-017 A printable byte at col COLS-1 SHALL be written as in REQ-016 and SHALL then perform a newline.
REQ-018 Newline: col is set to 0; row is set to row+1, or to 0 when row = ROWS-1. The FSM then enters CLR_LINE.
REQ-019 CLR_LINE SHALL last exactly COLS cycles (N+1..N+COLS) and issue BLANK writes to new_row*COLS+0..COLS-1 in ascending order, visible on cycles N+2..N+COLS+1. in_ready SHALL return to 1 on cycle N+COLS+1.
REQ-020 0x0A (LF) SHALL perform a newline with no character write.
REQ-021 0x0D (CR) SHALL set col to 0, with no write.
REQ-022 0x08 (BS) with col>0 SHALL decrement col and write BLANK at the new cursor cell on cycle N+1; with col=0 it SHALL be accepted as a no-op.
REQ-023 0x0C (FF) SHALL enter CLR_ALL and set the cursor to (0,0).
REQ-024 CLR_ALL SHALL last ROWS*COLS cycles and write BLANK to addresses 0..ROWS*COLS-1 in ascending order, one per cycle; it then returns to IDLE.
REQ-025 All other bytes below 0x20, and 0x7F, SHALL be accepted and ignored: no write, cursor unchanged.
REQ-026 vram_we SHALL be 0 on every cycle with no scheduled write; vram_waddr and vram_wdata hold their last values while vram_we is 0.
REQ-027 in_valid and in_data SHALL be ignored outside IDLE; a held in_valid is accepted on the first cycle IDLE is reached.
REQ-028 Address arithmetic SHALL use a running row-base register, which adds COLS per row and wraps to 0 after row ROWS-1; no address SHALL ever be >= ROWS*COLS.

Reset
REQ-029 While rst_n=0: vram_we=0, vram_waddr=0, vram_wdata=0, in_ready=0, cursor=(0,0), state=CLR_ALL.
REQ-030 After rst_n rises, the block SHALL run a full CLR_ALL (REQ-024) before in_ready first asserts.
REQ-031 rst_n asserted mid-operation (any state) SHALL abort that operation immediately and restart per REQ-029/REQ-030.

Verification
REQ-032 Reset release -> 1200 writes of 0x20 to addresses 0..1199, one per cycle, then in_ready=1 and cursor=(0,0).
REQ-033 Send 'A' (0x41) at cursor (0,0) on cycle N -> on N+1 vram_we=1, addr=0, data=0x41; cursor becomes (0,1).
REQ-034 Send 40 printable bytes from (0,0) -> addresses 0..39 written; then 40 BLANK writes to 40..79; in_ready low for exactly 40 cycles; cursor=(1,0).
REQ-035 Cursor at (29,5), send 0x0A -> cursor=(0,0); BLANK writes to addresses 0..39; no write to row 29.
REQ-036 Cursor at (3,0), send 0x08 -> accepted, no write, cursor unchanged. Cursor at (3,7), send 0x08 -> BLANK written to address 126, cursor=(3,6).
REQ-037 Send 0x0C mid-screen, then pulse rst_n low at clear cell 500 -> outputs go to reset values; a full 0..1199 clear restarts after release.
